// File: rtl/sum_it_up_pkg.sv
// Shared types and error codes for the sum_it_up accumulator.
package sum_it_up_pkg;

  localparam int unsigned ERR_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] ERR_NONE = 2'd0;
  localparam logic [ERR_W-1:0] ERR_UOVF = 2'd1;
  localparam logic [ERR_W-1:0] ERR_SOVF = 2'd2;
  localparam logic [ERR_W-1:0] ERR_COVF = 2'd3;

endpackage

// File: rtl/sum_it_up_param_sat_adder.sv
// Combinational WIDTH-bit adder with signed/unsigned overflow detect and saturation value.
module sat_adder #(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic [WIDTH-1:0] sum_c,
  output logic             ovf_c,
  output logic [WIDTH-1:0] sat_c
);

  logic [WIDTH:0] wide;
  logic           s_ovf;

  assign wide  = {1'b0, a} + {1'b0, b};
  assign sum_c = wide[WIDTH-1:0];

  // Signed overflow: like-signed operands producing an opposite-signed result.
  assign s_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (wide[WIDTH-1] != a[WIDTH-1]);

  assign ovf_c = is_signed ? s_ovf : wide[WIDTH];

  // Saturate toward the sign of the incoming operand.
  assign sat_c = !is_signed  ? {WIDTH{1'b1}} :
                 b[WIDTH-1]  ? {1'b1, {(WIDTH-1){1'b0}}} :
                               {1'b0, {(WIDTH-1){1'b1}}};

endmodule

// File: rtl/sum_it_up_param.sv
// Zero-terminated stream accumulator with signed/unsigned mode, optional saturation and sticky error.
module sum_it_up_param
  import sum_it_up_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned CNT_W  = 8,
  parameter int unsigned SAT_EN = 0
) (
  input  logic             ck,
  input  logic             reset,
  input  logic             go_l,
  input  logic             mode_signed,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] inA,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [ERR_W-1:0] err_code,
  output logic [WIDTH-1:0] sum,
  output logic [CNT_W-1:0] count
);

  localparam bit               SAT     = (SAT_EN != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state;
  logic             mode_r;
  logic [WIDTH-1:0] add_sum_c;
  logic             add_ovf_c;
  logic [WIDTH-1:0] add_sat_c;
  logic             cnt_ovf_c;
  logic             term_c;

  sat_adder #(.WIDTH(WIDTH)) u_add (
    .a         (sum),
    .b         (inA),
    .is_signed (mode_r),
    .sum_c     (add_sum_c),
    .ovf_c     (add_ovf_c),
    .sat_c     (add_sat_c)
  );

  assign cnt_ovf_c = (count == CNT_MAX);
  assign term_c    = (inA == '0);

  always_ff @(posedge ck or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mode_r   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
      err_code <= ERR_NONE;
      sum      <= '0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (!go_l) begin
            sum      <= '0;
            count    <= '0;
            error    <= 1'b0;
            err_code <= ERR_NONE;
            mode_r   <= mode_signed;
            busy     <= 1'b1;
            state    <= ACC;
          end
        end

        ACC: begin
          if (in_valid) begin
            if (term_c) begin
              done  <= !error;
              busy  <= 1'b0;
              state <= IDLE;
            end else if (add_ovf_c) begin
              // Arithmetic code takes priority; sticky code survives later faults.
              error <= 1'b1;
              if (!error) err_code <= mode_r ? ERR_SOVF : ERR_UOVF;
              if (SAT && !cnt_ovf_c) begin
                sum   <= add_sat_c;
                count <= count + CNT_W'(1);
              end else begin
                state <= DRAIN;
              end
            end else if (cnt_ovf_c) begin
              error <= 1'b1;
              if (!error) err_code <= ERR_COVF;
              state <= DRAIN;
            end else begin
              sum   <= add_sum_c;
              count <= count + CNT_W'(1);
            end
          end
        end

        DRAIN: begin
          if (in_valid && term_c) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sum_it_up_param.sv
// Directed bench: three accumulator configurations driven by shared stimulus.
module tb_sum_it_up_param;

  logic       ck = 1'b0;
  logic       reset;
  logic       go_l;
  logic       mode_signed;
  logic       in_valid;
  logic [7:0] inA;

  logic       busy0, done0, error0;
  logic [1:0] err0;
  logic [7:0] sum0, cnt0;
  logic       busy1, done1, error1;
  logic [1:0] err1;
  logic [7:0] sum1, cnt1;
  logic       busy2, done2, error2;
  logic [1:0] err2;
  logic [7:0] sum2;
  logic [1:0] cnt2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 ck = ~ck;

  // Wrap mode: freeze and drain on overflow.
  sum_it_up_param #(.WIDTH(8), .CNT_W(8), .SAT_EN(0)) u_dut0 (
    .ck(ck), .reset(reset), .go_l(go_l), .mode_signed(mode_signed),
    .in_valid(in_valid), .inA(inA), .busy(busy0), .done(done0),
    .error(error0), .err_code(err0), .sum(sum0), .count(cnt0));

  // Saturating mode.
  sum_it_up_param #(.WIDTH(8), .CNT_W(8), .SAT_EN(1)) u_dut1 (
    .ck(ck), .reset(reset), .go_l(go_l), .mode_signed(mode_signed),
    .in_valid(in_valid), .inA(inA), .busy(busy1), .done(done1),
    .error(error1), .err_code(err1), .sum(sum1), .count(cnt1));

  // Narrow counter for count overflow.
  sum_it_up_param #(.WIDTH(8), .CNT_W(2), .SAT_EN(0)) u_dut2 (
    .ck(ck), .reset(reset), .go_l(go_l), .mode_signed(mode_signed),
    .in_valid(in_valid), .inA(inA), .busy(busy2), .done(done2),
    .error(error2), .err_code(err2), .sum(sum2), .count(cnt2));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic start(input logic m);
    @(negedge ck);
    go_l        = 1'b0;
    mode_signed = m;
    @(negedge ck);
    go_l        = 1'b1;
  endtask

  // Present one valid operand for a single cycle; returns on the following negedge.
  task automatic op(input logic [7:0] v);
    @(negedge ck);
    in_valid = 1'b1;
    inA      = v;
    @(negedge ck);
    in_valid = 1'b0;
    inA      = 8'd0;
  endtask

  initial begin
    reset = 1'b1; go_l = 1'b1; mode_signed = 1'b0; in_valid = 1'b0; inA = 8'd0;
    repeat (2) @(negedge ck);
    check("rst_sum",   32'(sum0),   32'd0);
    check("rst_count", 32'(cnt0),   32'd0);
    check("rst_busy",  32'(busy0),  32'd0);
    check("rst_err",   32'({error0, err0}), 32'd0);
    reset = 1'b0;

    // 1: clean unsigned run.
    start(1'b0);
    check("t1_busy", 32'(busy0), 32'd1);
    op(8'd10); op(8'd20); op(8'd30);
    check("t1_sum_mid", 32'(sum0), 32'd60);
    op(8'd0);
    check("t1_done",  32'(done0), 32'd1);
    check("t1_sum",   32'(sum0),  32'd60);
    check("t1_count", 32'(cnt0),  32'd3);
    check("t1_error", 32'(error0), 32'd0);
    check("t1_busy_low", 32'(busy0), 32'd0);
    @(negedge ck);
    check("t1_done_pulse", 32'(done0), 32'd0);
    check("t1_sum_hold",   32'(sum0),  32'd60);

    // 2: unsigned overflow without saturation.
    start(1'b0);
    op(8'd200); op(8'd100);
    check("t2_err",   32'({error0, err0}), 32'd5);
    check("t2_sum",   32'(sum0), 32'd200);
    check("t2_busy",  32'(busy0), 32'd1);
    op(8'd5);
    check("t2_drain_sum",   32'(sum0), 32'd200);
    check("t2_drain_count", 32'(cnt0), 32'd1);
    op(8'd0);
    check("t2_no_done", 32'(done0), 32'd0);
    check("t2_idle",    32'(busy0), 32'd0);
    check("t2_err_stk", 32'(err0),  32'd1);

    // 3: signed saturation keeps accumulating.
    start(1'b1);
    op(8'd100); op(8'd50);
    check("t3_sat", 32'(sum1), 32'd127);
    check("t3_err", 32'({error1, err1}), 32'd6);
    op(8'd226);
    check("t3_sum",   32'(sum1), 32'd97);
    check("t3_count", 32'(cnt1), 32'd3);
    op(8'd0);
    check("t3_no_done", 32'(done1), 32'd0);
    check("t3_err_end", 32'(err1),  32'd2);

    // 4: signed negative overflow, then a clean restart.
    start(1'b1);
    op(8'd156); op(8'd206);
    check("t4_err", 32'(err0), 32'd2);
    check("t4_sum", 32'(sum0), 32'd156);
    op(8'd0);
    check("t4_no_done", 32'(done0), 32'd0);
    start(1'b1);
    check("t4_err_clr", 32'({error0, err0}), 32'd0);
    check("t4_sum_clr", 32'(sum0), 32'd0);
    op(8'd1); op(8'd0);
    check("t4_sum2", 32'(sum0),  32'd1);
    check("t4_done", 32'(done0), 32'd1);

    // 5: counter overflow on the narrow instance.
    start(1'b0);
    op(8'd1); op(8'd1); op(8'd1); op(8'd1);
    check("t5_err",   32'({error2, err2}), 32'd7);
    check("t5_count", 32'(cnt2), 32'd3);
    check("t5_sum",   32'(sum2), 32'd3);
    op(8'd0);
    check("t5_no_done", 32'(done2), 32'd0);
    check("t5_idle",    32'(busy2), 32'd0);

    // 6a: asynchronous reset mid-accumulation.
    start(1'b0);
    op(8'd5); op(8'd7);
    check("t6_sum_pre", 32'(sum0), 32'd12);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_sum",  32'(sum0),  32'd0);
    check("t6_rst_cnt",  32'(cnt0),  32'd0);
    check("t6_rst_busy", 32'(busy0), 32'd0);
    @(negedge ck);
    reset = 1'b0;

    // 6b: go_l while busy is ignored.
    start(1'b0);
    op(8'd5);
    @(negedge ck); go_l = 1'b0;
    @(negedge ck); go_l = 1'b1;
    check("t6_go_ign_sum", 32'(sum0), 32'd5);
    check("t6_go_ign_cnt", 32'(cnt0), 32'd1);
    op(8'd7); op(8'd0);
    check("t6_sum",  32'(sum0),  32'd12);
    check("t6_done", 32'(done0), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_it_up_param.md
Name: sum_it_up_param

Overview:
Parametrised next-generation accumulator. Sums a stream of WIDTH-bit operands terminated by a zero operand. Supports unsigned or two's-complement signed mode, optional saturation, an operand counter, and a sticky error with a cause code. Sits between an operand source using a valid strobe and a consumer that samples sum/count on done.

Parameters:
WIDTH, 16, operand and sum width in bits (>= 2)
CNT_W, 8, operand counter width; max count = 2**CNT_W-1
SAT_EN, 0, 1 = saturate on overflow and keep accumulating; 0 = freeze sum and drain on overflow

Ports:
ck  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
go_l  in  1  active-low start request; sampled only in IDLE
mode_signed  in  1  1 = signed accumulate, 0 = unsigned; captured at start
in_valid  in  1  inA valid this cycle (no backpressure; consumed when busy)
inA  in  WIDTH  operand; value 0 = terminator
busy  out  1  high in ACC or DRAIN
done  out  1  one-cycle pulse: clean completion
error  out  1  sticky error flag
err_code  out  2  0 none, 1 unsigned overflow, 2 signed overflow, 3 count overflow
sum  out  WIDTH  running/final sum
count  out  CNT_W  nonzero operands accepted

Behaviour:
- Interface: one clock ck, reset is asynchronous and active-high.
- Reset: state=IDLE; sum, count, err_code=0; busy, done, error=0; mode register=0.
- IDLE: outputs hold the last result. When go_l=0: sum<=0, count<=0, error<=0, err_code<=0, mode<=mode_signed, then go to ACC. in_valid is ignored in IDLE.
- ACC, in_valid=1, inA!=0: use a WIDTH+1 bit add.
  - Unsigned overflow = carry out.
  - Signed overflow = operands have the same sign and the result sign differs.
  - Count overflow = count==2**CNT_W-1 before the increment.
- ACC, no overflow: sum<=sum+inA, count<=count+1.
- ACC, arithmetic overflow: error<=1; err_code<=1 (unsigned) or 2 (signed).
  - SAT_EN=1: sum<=saturated value (unsigned: all ones; signed: +max if inA positive, else -min). count increments. Stay in ACC.
  - SAT_EN=0: sum holds its pre-overflow value. count does not increment. Go to DRAIN.
- ACC, count overflow only: error<=1, err_code<=3, sum and count hold, go to DRAIN (for both SAT_EN values).
  - If arithmetic overflow and count overflow coincide, the arithmetic code wins; the transition is still to DRAIN.
- Sticky error: once set, err_code is not overwritten until the next start.
- ACC, in_valid=1, inA==0: go to IDLE.
  - done=1 for exactly the next cycle (registered) if error==0.
  - No done if error==1, including saturation runs.
- DRAIN: valid operands are discarded, and sum/count are frozen. A valid zero goes to IDLE with no done.
- go_l is ignored while busy; no restart mid-operation.
- in_valid=0: no change in any state.
- done and error are never high in the same cycle.
- Asynchronous reset mid-operation: immediate return to reset values; no done.
- Latency: terminator accepted at edge N gives done high during cycle N..N+1; sum/count are final and stable from edge N until the next start.

Decomposition:
- Package sum_it_up_pkg: state enum (IDLE, ACC, DRAIN) and err_code localparams (ERR_NONE, ERR_UOVF, ERR_SOVF, ERR_COVF).
- One sub-module, sat_adder, is natural: combinational, parametrised WIDTH, signed/unsigned select. Outputs the wrapped sum, overflow flag and saturated value. FSM, counter and registers stay in the top.

Test Plan:
1. WIDTH=8, unsigned, go, operands 10,20,30,0 -> sum=60, count=3, done one-cycle pulse, error=0, busy low after.
2. Unsigned, SAT_EN=0, operands 200,100,5,0 -> error=1, err_code=1, sum frozen at 200, count=1, 5 discarded in DRAIN, no done, IDLE.
3. Signed, SAT_EN=1, operands 100,50,-30,0 -> sum 127 after 50, then 97; count=3, error=1, err_code=2, no done.
4. Signed, SAT_EN=0, operands -100,-50,0 -> err_code=2, sum=-100, no done. Next go then 1,0 -> error clears at start, sum=1, done pulses.
5. CNT_W=2, unsigned, operands 1,1,1,1,0 -> fourth operand raises err_code=3, count=3, sum=3, DRAIN, no done.
6. Reset asserted mid-ACC after 5,7 -> all outputs 0 immediately. go_l pulse while busy in another run -> ignored, sum unaffected.
